// File: rtl/up3_pkg.sv
// up3 shared definitions: sequencer states, opcodes, decoded instruction
// class, the strobe bundle driven to the datapath and the state transition
// function used by the control sequencer.
package up3_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned CLASS_W = 7;

    // Instruction opcodes (upper byte of the two-byte instruction)
    localparam logic [OP_W-1:0] OP_ADD   = 8'h00;
    localparam logic [OP_W-1:0] OP_SUB   = 8'h01;
    localparam logic [OP_W-1:0] OP_LOAD  = 8'h02;
    localparam logic [OP_W-1:0] OP_LOADI = 8'h03;
    localparam logic [OP_W-1:0] OP_STORE = 8'h04;
    localparam logic [OP_W-1:0] OP_JUMP  = 8'h05;
    localparam logic [OP_W-1:0] OP_JNEG  = 8'h06;
    localparam logic [OP_W-1:0] OP_JZERO = 8'h07;
    localparam logic [OP_W-1:0] OP_HALT  = 8'hFF;

    // Sequencer states; one instruction walks FETCH_U..EXECUTE in 6 cycles
    typedef enum logic [2:0] {
        S_FETCH_U = 3'd0,
        S_LOAD_U  = 3'd1,
        S_FETCH_L = 3'd2,
        S_LOAD_L  = 3'd3,
        S_DECODE  = 3'd4,
        S_EXECUTE = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    // One-hot instruction class produced by up3_decode
    typedef struct packed {
        logic alu_ld;
        logic store;
        logic jmp;
        logic jneg;
        logic jzero;
        logic halt;
        logic nop;
    } op_class_t;

    // Strobes driven towards the datapath
    typedef struct packed {
        logic load_pc;
        logic load_ac;
        logic load_iru;
        logic load_irl;
        logic fetch;
        logic store_mem;
        logic incr_pc;
    } strobes_t;

    // Strobe values held by the register while in reset (state FETCH_U)
    localparam strobes_t STROBES_RST = '{
        load_pc:   1'b0,
        load_ac:   1'b0,
        load_iru:  1'b0,
        load_irl:  1'b0,
        fetch:     1'b1,
        store_mem: 1'b0,
        incr_pc:   1'b0
    };

    // Fixed fetch/decode/execute walk; HALT is a sink left only via reset
    function automatic state_t next_state(input state_t cur, input logic halt_op);
        state_t nxt;
        case (cur)
            S_FETCH_U: nxt = S_LOAD_U;
            S_LOAD_U:  nxt = S_FETCH_L;
            S_FETCH_L: nxt = S_LOAD_L;
            S_LOAD_L:  nxt = S_DECODE;
            S_DECODE:  nxt = S_EXECUTE;
            S_EXECUTE: nxt = halt_op ? S_HALT : S_FETCH_U;
            S_HALT:    nxt = S_HALT;
            default:   nxt = S_FETCH_U;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/up3_decode.sv
// Combinational opcode classifier shared by the control sequencer and ALU.
// Ports:
//   opcode    in   instruction upper byte
//   op_class  out  one-hot {alu_ld, store, jmp, jneg, jzero, halt, nop}
module up3_decode
    import up3_pkg::*;
(
    input  logic [OP_W-1:0]    opcode,
    output logic [CLASS_W-1:0] op_class
);

    op_class_t cls;

    // Unknown opcodes fall into the nop class
    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_LOAD, OP_LOADI: cls.alu_ld = 1'b1;
            OP_STORE:                          cls.store  = 1'b1;
            OP_JUMP:                           cls.jmp    = 1'b1;
            OP_JNEG:                           cls.jneg   = 1'b1;
            OP_JZERO:                          cls.jzero  = 1'b1;
            OP_HALT:                           cls.halt   = 1'b1;
            default:                           cls.nop    = 1'b1;
        endcase
    end

    assign op_class = CLASS_W'(cls);

endmodule

// File: rtl/up3_control.sv
// up3 control sequencer: Moore FSM stepping fetch/decode/execute for each
// two-byte instruction and counting retired instructions.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   opcode     in   IR upper byte
//   nflg/zflg  in   ALU negative / zero flags, used in EXECUTE only
//   LOAD_PC, LOAD_AC, LOAD_IRU, LOAD_IRL, STORE_MEM, INCR_PC
//              out  datapath strobes, forced low while reset is low
//   fetch      out  address mux select (1 = PC, 0 = IR value field)
//   halted     out  processor stopped
//   instr_cnt  out  retired-instruction counter, wraps
module up3_control
    import up3_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opcode,
    input  logic             nflg,
    input  logic             zflg,
    output logic             LOAD_PC,
    output logic             LOAD_AC,
    output logic             LOAD_IRU,
    output logic             LOAD_IRL,
    output logic             fetch,
    output logic             STORE_MEM,
    output logic             INCR_PC,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [CLASS_W-1:0] class_bits;
    op_class_t          cls;

    state_t   state;
    state_t   state_nxt;
    strobes_t strb_q;
    strobes_t strb_nxt;
    logic     halted_q;
    logic     halted_nxt;
    logic     jneg_q;
    logic     jneg_nxt;
    logic     jzero_q;
    logic     jzero_nxt;
    logic [CNT_W-1:0] cnt_q;

    up3_decode u_decode (
        .opcode   (opcode),
        .op_class (class_bits)
    );

    assign cls = op_class_t'(class_bits);

    // Next state and the strobes that state will present once registered
    always_comb begin
        state_nxt  = next_state(state, cls.halt);
        strb_nxt   = '0;
        halted_nxt = 1'b0;
        jneg_nxt   = 1'b0;
        jzero_nxt  = 1'b0;
        case (state_nxt)
            S_FETCH_U, S_FETCH_L: begin
                strb_nxt.fetch = 1'b1;
            end
            S_LOAD_U: begin
                strb_nxt.fetch    = 1'b1;
                strb_nxt.load_iru = 1'b1;
                strb_nxt.incr_pc  = 1'b1;
            end
            S_LOAD_L: begin
                strb_nxt.fetch    = 1'b1;
                strb_nxt.load_irl = 1'b1;
                strb_nxt.incr_pc  = 1'b1;
            end
            S_EXECUTE: begin
                // Conditional jumps are armed here; the flags themselves are
                // applied during EXECUTE so they reflect the current AC.
                if (!cls.nop) begin
                    strb_nxt.load_ac   = cls.alu_ld;
                    strb_nxt.store_mem = cls.store;
                    strb_nxt.load_pc   = cls.jmp;
                    jneg_nxt           = cls.jneg;
                    jzero_nxt          = cls.jzero;
                end
            end
            S_HALT: begin
                halted_nxt = 1'b1;
            end
            default: begin
                strb_nxt = '0;
            end
        endcase
    end

    // State, registered strobes and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_FETCH_U;
            strb_q   <= STROBES_RST;
            halted_q <= 1'b0;
            jneg_q   <= 1'b0;
            jzero_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            strb_q   <= strb_nxt;
            halted_q <= halted_nxt;
            jneg_q   <= jneg_nxt;
            jzero_q  <= jzero_nxt;
            if (state == S_EXECUTE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Load/write strobes are gated by reset so nothing leaks in a reset cycle
    assign LOAD_PC   = reset & (strb_q.load_pc | (jneg_q & nflg) | (jzero_q & zflg));
    assign LOAD_AC   = reset & strb_q.load_ac;
    assign LOAD_IRU  = reset & strb_q.load_iru;
    assign LOAD_IRL  = reset & strb_q.load_irl;
    assign STORE_MEM = reset & strb_q.store_mem;
    assign INCR_PC   = reset & strb_q.incr_pc;
    assign fetch     = strb_q.fetch;
    assign halted    = halted_q;
    assign instr_cnt = cnt_q;

    // Datapath write/load strobes are mutually exclusive
    a_excl_writes : assert property (@(posedge clk) disable iff (!reset)
        $onehot0({LOAD_AC, STORE_MEM, LOAD_PC}));
    a_pc_excl : assert property (@(posedge clk) disable iff (!reset)
        !(INCR_PC && LOAD_PC));

endmodule

// File: tb/tb_up3_control.sv
// Bench for up3_control: directed and random instruction streams checked
// against a per-cycle model of the instruction timeline.
module tb_up3_control;

    logic       clk;
    logic       reset;
    logic [7:0] opcode;
    logic       nflg;
    logic       zflg;

    logic        ld_pc_a, ld_ac_a, iru_a, irl_a, fetch_a, st_a, inc_a, halted_a;
    logic [15:0] cnt_a;
    logic        ld_pc_b, ld_ac_b, iru_b, irl_b, fetch_b, st_b, inc_b, halted_b;
    logic [3:0]  cnt_b;

    up3_control #(.CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode), .nflg(nflg), .zflg(zflg),
        .LOAD_PC(ld_pc_a), .LOAD_AC(ld_ac_a), .LOAD_IRU(iru_a), .LOAD_IRL(irl_a),
        .fetch(fetch_a), .STORE_MEM(st_a), .INCR_PC(inc_a), .halted(halted_a),
        .instr_cnt(cnt_a)
    );

    up3_control #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .nflg(nflg), .zflg(zflg),
        .LOAD_PC(ld_pc_b), .LOAD_AC(ld_ac_b), .LOAD_IRU(iru_b), .LOAD_IRL(irl_b),
        .fetch(fetch_b), .STORE_MEM(st_b), .INCR_PC(inc_b), .halted(halted_b),
        .instr_cnt(cnt_b)
    );

    logic [7:0] vec_a;
    logic [7:0] vec_b;
    assign vec_a = {ld_pc_a, ld_ac_a, iru_a, irl_a, fetch_a, st_a, inc_a, halted_a};
    assign vec_b = {ld_pc_b, ld_ac_b, iru_b, irl_b, fetch_b, st_b, inc_b, halted_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: cycle position within the current instruction (0..5),
    // halt flag and an unbounded retired-instruction count.
    int          phase_m  = 0;
    bit          halted_m = 1'b0;
    int unsigned cnt_m    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Expected {LOAD_PC,LOAD_AC,LOAD_IRU,LOAD_IRL,fetch,STORE_MEM,INCR_PC,halted}
    function automatic logic [7:0] model_vec(input int ph, input bit hlt, input logic [7:0] op,
                                             input logic nf, input logic zf, input logic rst);
        logic lpc, lac, iru, irl, fch, st, inc;
        lpc = 0; lac = 0; iru = 0; irl = 0; fch = 0; st = 0; inc = 0;
        if (hlt) return 8'b0000_0001;
        case (ph)
            0: fch = 1;
            1: begin fch = 1; iru = 1; inc = 1; end
            2: fch = 1;
            3: begin fch = 1; irl = 1; inc = 1; end
            5: begin
                if (op <= 8'h03)      lac = 1;
                else if (op == 8'h04) st  = 1;
                else if (op == 8'h05) lpc = 1;
                else if (op == 8'h06) lpc = nf;
                else if (op == 8'h07) lpc = zf;
            end
            default: ;
        endcase
        if (!rst) begin
            lpc = 0; lac = 0; iru = 0; irl = 0; st = 0; inc = 0;
        end
        return {lpc, lac, iru, irl, fch, st, inc, 1'b0};
    endfunction

    // One clock: drive inputs, check against model, advance model, wait
    task automatic tick(input logic rst, input logic [7:0] op, input logic nf, input logic zf);
        logic [7:0] ev;
        reset = rst; opcode = op; nflg = nf; zflg = zf;
        #1;
        ev = model_vec(phase_m, halted_m, op, nf, zf, rst);
        check_val($sformatf("vec_a ph%0d op%h", phase_m, op), 32'(vec_a), 32'(ev));
        check_val($sformatf("vec_b ph%0d op%h", phase_m, op), 32'(vec_b), 32'(ev));
        check_val("cnt_a", 32'(cnt_a), cnt_m & 32'hFFFF);
        check_val("cnt_b", 32'(cnt_b), cnt_m & 32'hF);
        if (!rst) begin
            phase_m = 0; halted_m = 0; cnt_m = 0;
        end else if (!halted_m) begin
            if (phase_m == 5) begin
                cnt_m++;
                phase_m = 0;
                if (op == 8'hFF) halted_m = 1;
            end else begin
                phase_m++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [7:0] op, input logic nf, input logic zf);
        for (int i = 0; i < 6; i++) tick(1'b1, op, nf, zf);
    endtask

    task automatic run_instr_rnd(input logic [7:0] op);
        for (int i = 0; i < 6; i++) tick(1'b1, op, 1'($urandom), 1'($urandom));
    endtask

    task automatic hold_halt_then_reset(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] pick_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 2)  return 8'hFF;
        if (r < 66) return 8'(r % 8);
        if (r < 80) return 8'h20;
        return 8'($urandom);
    endfunction

    initial begin
        reset = 1'b0; opcode = 8'h00; nflg = 1'b0; zflg = 1'b0;
        @(negedge clk);
        phase_m = 0; halted_m = 0; cnt_m = 0;

        // Reset held: fetch=1, gated strobes, counter cleared
        tick(1'b0, 8'h04, 1'b1, 1'b1);
        tick(1'b0, 8'h04, 1'b1, 1'b1);

        // Directed instructions
        run_instr(8'h00, 1'b0, 1'b0);
        check_val("cnt_after_add", 32'(cnt_a), 32'd1);
        run_instr(8'h06, 1'b1, 1'b0);
        run_instr(8'h06, 1'b0, 1'b1);
        run_instr(8'h04, 1'b1, 1'b1);
        run_instr(8'h07, 1'b0, 1'b1);
        run_instr(8'h07, 1'b1, 1'b0);
        run_instr(8'h05, 1'b0, 1'b0);
        run_instr(8'h03, 1'b1, 1'b1);

        // 16 NOPs: the 4-bit counter wraps
        for (int k = 0; k < 16; k++) run_instr_rnd(8'h20);

        // Reset asserted while a STORE sits in EXECUTE
        for (int i = 0; i < 5; i++) tick(1'b1, 8'h04, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            reset = 1'b0;
            #1;
            check_val("rst_store_mem", 32'(st_a), 32'd0);
            tick(1'b0, 8'h04, 1'b0, 1'b0);
        end

        // Random instruction stream with occasional halts
        for (int k = 0; k < 300; k++) begin
            run_instr_rnd(pick_op());
            if (halted_m) hold_halt_then_reset(int'($urandom_range(20, 30)));
        end

        // Final directed halt
        run_instr_rnd(8'h01);
        run_instr_rnd(8'hFF);
        hold_halt_then_reset(22);
        run_instr_rnd(8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
